user_interface_ctrl: RTL and testbench

- Parametrised successor to the telephony front-panel user interface.
- Conditions the raw enter/up/down/left/right buttons:
  - synchronises them,
  - debounces them,
  - auto-repeats up/down while held.
- A menu FSM uses those events to let the user build a destination address and select a command.
- The selected (address, command) pair is issued to the call-control logic over a valid/ready handshake.

---
 rtl/user_interface_ctrl.sv | 161 ++++++++++++++++
 tb/tb_user_interface_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/user_interface_ctrl.sv
// rtl/user_interface_ctrl.sv - front-panel button conditioning and menu FSM issuing address/command pairs
module user_interface_ctrl #(
  parameter int ADDR_W          = 8,
  parameter int CMD_W           = 3,
  parameter int NUM_CMDS        = 6,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int REPEAT_DELAY    = 8100000,
  parameter int REPEAT_RATE     = 2700000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enter,
  input  logic              up,
  input  logic              down,
  input  logic              left,
  input  logic              right,
  input  logic [ADDR_W-1:0] sw,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] address,
  output logic [CMD_W-1:0]  command,
  output logic              cmd_valid,
  output logic [1:0]        state
);

  localparam int NB     = 5;
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RP_W   = $clog2(RP_MAX + 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CMD_W-1:0] CMD_LAST = CMD_W'(NUM_CMDS - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADDR = 2'd1, S_CMD = 2'd2, S_ISSUE = 2'd3} state_t;

  // Button index order: 0 enter, 1 left, 2 right, 3 up, 4 down
  logic [NB-1:0]   w_raw;
  logic [NB-1:0]   r_sync1, r_sync2, r_deb, r_press;
  logic [NB-1:0]   w_flip;
  logic [DB_W-1:0] r_db_cnt [NB];
  logic [RP_W-1:0] r_rep_cnt [2];
  logic [1:0]      r_rep_phase, r_rep_evt;

  assign w_raw = {down, up, right, left, enter};

  always_comb begin
    w_flip = '0;
    for (int i = 0; i < NB; i++) begin
      w_flip[i] = (r_sync2[i] != r_deb[i]) && (r_db_cnt[i] == DB_LAST);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_press <= '0;
      for (int i = 0; i < NB; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < NB; i++) begin
        r_press[i] <= w_flip[i] & r_sync2[i];
        if (r_sync2[i] == r_deb[i] || w_flip[i]) begin
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
        if (w_flip[i]) r_deb[i] <= r_sync2[i];
      end
    end
  end

  // Repeat counter starts at 1 on the accepting edge so it fires REPEAT_DELAY clocks after the press event
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rep_phase <= '0;
      r_rep_evt   <= '0;
      for (int j = 0; j < 2; j++) r_rep_cnt[j] <= '0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        r_rep_evt[j] <= 1'b0;
        if (w_flip[j+3]) begin
          r_rep_cnt[j]   <= RP_W'(1);
          r_rep_phase[j] <= 1'b0;
        end else if (!r_deb[j+3]) begin
          r_rep_cnt[j]   <= '0;
          r_rep_phase[j] <= 1'b0;
        end else if (r_rep_cnt[j] == (r_rep_phase[j] ? RP_W'(REPEAT_RATE) : RP_W'(REPEAT_DELAY))) begin
          r_rep_evt[j]   <= 1'b1;
          r_rep_cnt[j]   <= RP_W'(1);
          r_rep_phase[j] <= 1'b1;
        end else begin
          r_rep_cnt[j] <= r_rep_cnt[j] + RP_W'(1);
        end
      end
    end
  end

  logic w_enter, w_left, w_right, w_up, w_down;
  assign w_enter = r_press[0];
  assign w_left  = r_press[1] & ~r_press[0];
  assign w_right = r_press[2] & ~(r_press[0] | r_press[1]);
  assign w_up    = (r_press[3] | r_rep_evt[0]) & ~(r_press[0] | r_press[1] | r_press[2]);
  assign w_down  = (r_press[4] | r_rep_evt[1]) & ~(r_press[0] | r_press[1] | r_press[2] |
                                                   r_press[3] | r_rep_evt[0]);

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_address, w_addr_next;
  logic [CMD_W-1:0]  r_command, w_cmd_next;
  logic              r_cmd_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_address   <= '0;
      r_command   <= '0;
      r_cmd_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_address   <= w_addr_next;
      r_command   <= w_cmd_next;
      r_cmd_valid <= (w_state_next == S_ISSUE);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_address;
    w_cmd_next   = r_command;
    case (r_state)
      S_IDLE: begin
        if (w_enter) w_state_next = S_ADDR;
      end
      S_ADDR: begin
        if (w_enter)      w_state_next = S_CMD;
        else if (w_left)  w_state_next = S_IDLE;
        else if (w_right) w_addr_next  = sw;
        else if (w_up)    w_addr_next  = r_address + ADDR_W'(1);
        else if (w_down)  w_addr_next  = r_address - ADDR_W'(1);
      end
      S_CMD: begin
        if (w_enter)     w_state_next = S_ISSUE;
        else if (w_left) w_state_next = S_ADDR;
        else if (w_up)   w_cmd_next   = (r_command == CMD_LAST) ? '0 : r_command + CMD_W'(1);
        else if (w_down) w_cmd_next   = (r_command == '0) ? CMD_LAST : r_command - CMD_W'(1);
      end
      S_ISSUE: begin
        // Handshake beats a coincident left-abort
        if (r_cmd_valid && cmd_ready) w_state_next = S_IDLE;
        else if (w_left)              w_state_next = S_CMD;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign address   = r_address;
  assign command   = r_command;
  assign cmd_valid = r_cmd_valid;
  assign state     = r_state;

endmodule

// File: tb/tb_user_interface_ctrl.sv
// tb/tb_user_interface_ctrl.sv - directed and randomized bench for user_interface_ctrl
module tb_user_interface_ctrl;

  localparam int ADDR_W = 8;
  localparam int CMD_W  = 3;
  localparam int NCMD   = 6;
  localparam int DB     = 4;
  localparam int RDLY   = 20;
  localparam int RRATE  = 5;
  localparam int SETTLE = 12;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              enter = 1'b0, up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic [ADDR_W-1:0] sw = '0;
  logic              cmd_ready = 1'b0;
  logic [ADDR_W-1:0] address;
  logic [CMD_W-1:0]  command;
  logic              cmd_valid;
  logic [1:0]        state;

  user_interface_ctrl #(
    .ADDR_W(ADDR_W), .CMD_W(CMD_W), .NUM_CMDS(NCMD),
    .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RDLY), .REPEAT_RATE(RRATE)
  ) dut (
    .clk(clk), .reset(reset), .enter(enter), .up(up), .down(down), .left(left), .right(right),
    .sw(sw), .cmd_ready(cmd_ready), .address(address), .command(command),
    .cmd_valid(cmd_valid), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int m_state  = 0;
  int m_addr   = 0;
  int m_cmd    = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_addr"}, 32'(address), 32'(m_addr));
    check({tag, "_cmd"}, 32'(command), 32'(m_cmd));
    check({tag, "_state"}, 32'(state), 32'(m_state));
    check({tag, "_valid"}, 32'(cmd_valid), 32'(m_state == 3));
  endtask

  // 0 enter, 1 left, 2 right, 3 up, 4 down
  task automatic set_btn(input int b, input logic v);
    case (b)
      0: enter = v;
      1: left  = v;
      2: right = v;
      3: up    = v;
      default: down = v;
    endcase
  endtask

  function automatic int n_events(input int b, input int h);
    int n;
    if (h < DB) return 0;
    n = 1;
    if (b >= 3) begin
      for (int t = RDLY; t < h; t += RRATE) n++;
    end
    return n;
  endfunction

  function automatic void model_event(input int b);
    case (m_state)
      0: if (b == 0) m_state = 1;
      1: begin
        if (b == 0) m_state = 2;
        else if (b == 1) m_state = 0;
        else if (b == 2) m_addr = int'(sw);
        else if (b == 3) m_addr = (m_addr + 1) % 256;
        else m_addr = (m_addr + 255) % 256;
      end
      2: begin
        if (b == 0) m_state = 3;
        else if (b == 1) m_state = 1;
        else if (b == 3) m_cmd = (m_cmd + 1) % NCMD;
        else if (b == 4) m_cmd = (m_cmd + NCMD - 1) % NCMD;
      end
      default: if (b == 1) m_state = 2;
    endcase
  endfunction

  task automatic press(input int b, input int h);
    set_btn(b, 1'b1);
    repeat (h) tick();
    set_btn(b, 1'b0);
    repeat (SETTLE) tick();
    for (int k = 0; k < n_events(b, h); k++) model_event(b);
  endtask

  initial begin
    int hs_cnt;
    int b, h;
    repeat (3) tick();
    check_all("reset");
    reset = 1'b1;
    tick();

    enter = 1'b1;
    repeat (6) tick();
    check("enter_not_before_6", 32'(state), 32'd0);
    tick();
    check("enter_at_6", 32'(state), 32'd1);
    repeat (3) tick();
    enter = 1'b0;
    repeat (SETTLE) tick();
    model_event(0);
    check_all("idle_to_addr");

    press(4, 5);
    check("addr_wrap_down", 32'(address), 32'hFF);
    press(3, 5);
    press(3, 5);
    check("addr_wrap_up", 32'(address), 32'h01);
    sw = 8'hA5;
    press(2, 5);
    check_all("addr_right");

    press(3, 3);
    check_all("glitch_up");

    up = 1'b1;
    repeat (40) tick();
    check("hold_up_4_events", 32'(address), 32'(m_addr + 4));
    up = 1'b0;
    repeat (SETTLE) tick();
    for (int k = 0; k < n_events(3, 40); k++) model_event(3);
    check_all("hold_up_release");

    press(0, 5);
    press(4, 5);
    check("cmd_wrap_down", 32'(command), 32'd5);
    press(3, 5);
    check("cmd_wrap_up", 32'(command), 32'd0);
    press(4, 5);
    check_all("cmd_back_5");

    up = 1'b1;
    down = 1'b1;
    repeat (5) tick();
    up = 1'b0;
    down = 1'b0;
    repeat (SETTLE) tick();
    model_event(3);
    check_all("up_beats_down");
    press(4, 5);

    press(0, 5);
    check_all("issue_enter");
    for (int k = 0; k < 10; k++) begin
      tick();
      check_all("issue_hold");
    end
    cmd_ready = 1'b1;
    hs_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (cmd_valid && cmd_ready) hs_cnt++;
      tick();
    end
    cmd_ready = 1'b0;
    check("handshake_once", 32'(hs_cnt), 32'd1);
    m_state = 0;
    check_all("after_handshake");

    press(0, 5);
    press(0, 5);
    press(0, 5);
    check_all("reissue");
    press(1, 5);
    check_all("left_abort");

    press(0, 5);
    left = 1'b1;
    repeat (6) tick();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    m_state = 0;
    check_all("left_vs_ready");
    left = 1'b0;
    repeat (SETTLE) tick();
    check_all("left_vs_ready_settle");

    for (int r = 0; r < 40; r++) begin
      b = int'($urandom_range(0, 4));
      h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DB - 1)) : int'($urandom_range(DB, 32));
      sw = ADDR_W'($urandom);
      press(b, h);
      check_all("random");
    end

    for (int k = 0; k < 4; k++) begin
      if (m_state != 3) press(0, 5);
    end
    check_all("pre_reset_issue");
    #2;
    reset = 1'b0;
    #1;
    m_state = 0;
    m_addr  = 0;
    m_cmd   = 0;
    check_all("async_reset");
    tick();
    check_all("async_reset_hold");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
